cpu_ddram_bridge: RTL and testbench
===================================

Name: cpu_ddram_bridge

Overview:
Converts an asynchronous 8-bit CPU memory cycle (level RD/WR strobes, WAIT output) into the toggle write handshake (we_req/we_ack) and edge-triggered read handshake (rd_req/rd_rdy) of the 8-bit DDRAM cache controller. Sits directly upstream of that controller in the DDRAM_CLK domain, between the Multicomp CPU bus decode and DDR3 access. Holds the CPU in wait until data is valid (read) or accepted (write). Extends the CPU address to 28 bits with a bank register.

Parameters:
CPU_AW, 16, CPU address width; bank supplies the upper 28-CPU_AW bits.
SYNC_STAGES, 2, flip-flop stages on cpu_rd/cpu_wr (minimum 2).

Ports:
DDRAM_CLK  in  1  sole clock; all logic posedge.
reset_n  in  1  asynchronous, active-low reset.
cpu_addr  in  CPU_AW  CPU byte address; stable while a strobe is high.
cpu_bank  in  28-CPU_AW  upper address bits; sampled with cpu_addr.
cpu_din  in  8  CPU write data.
cpu_rd  in  1  async read strobe, active high.
cpu_wr  in  1  async write strobe, active high.
cpu_dout  out  8  registered read data.
cpu_wait  out  1  high = stretch CPU cycle.
wraddr  out  28  to controller.
din  out  8  to controller.
we_req  out  1  toggle; a new write is requested when we_req != we_ack.
we_ack  in  1  controller ack.
rdaddr  out  28  to controller; held through the read.
dout  in  8  controller byte, valid while rd_rdy=1 and rdaddr is held.
rd_req  out  1  rising edge starts a read.
rd_rdy  in  1  controller ready.
dbg_state  out  3  current FSM state encoding.

Behaviour:
- Reset (reset_n=0, async): state=IDLE. we_req, rd_req, wraddr, rdaddr, din, cpu_dout, the done flag and the sync chains are all 0. cpu_wait is forced to 0.
- Strobes pass through SYNC_STAGES flops. rd_s and wr_s are the synced levels; edge detection is registered one stage beyond the chain.
- cpu_wait = (cpu_rd | cpu_wr) & ~done. It is combinational on the raw strobes so WAIT asserts immediately. done is a registered flag.
- IDLE:
  - Rising wr_s: wraddr={cpu_bank,cpu_addr}, din=cpu_din, we_req<=~we_req, go to WR.
  - Rising rd_s with no write edge: rdaddr={cpu_bank,cpu_addr}, rd_req<=1, go to RD_ARM.
  - Both edges in the same cycle: the write wins and the read edge is discarded; the CPU is expected to retry.
- WR: when we_ack==we_req, set done=1 and go to DONE.
- RD_ARM: wait for rd_rdy==0. The controller drops rd_rdy one cycle after sampling the rd_req rise; it may stay low for only one cycle on a cache hit. rd_rdy=1 here is stale and is ignored.
- RD_WAIT: when rd_rdy==1, cpu_dout<=dout, rd_req<=0, done=1, go to DONE. rdaddr stays unchanged until leaving DONE.
- DONE: when rd_s and wr_s are both 0, clear done and go to IDLE.
  - rd_req is guaranteed low for at least 1 cycle between reads, because it drops in RD_WAIT and a new rise needs IDLE.
- Minimum read latency with a cache hit, from synced edge to done: 4 cycles. Write latency is 1 cycle plus the controller ack time.
- Strobe that deasserts before completion: the transaction still completes (write performed / read data latched). cpu_wait is already low because the strobe is low.
- Reset mid-operation: all state is dropped with no partial write. The controller must be reset in the same window so that it resynchronises we_ack to we_req=0.
- we_req toggles at most once per transaction. A new transaction cannot start until the previous ack is received.

Optional Feature:
WR_POST_EN
- Defined: one-deep posted write. In IDLE, a write edge toggles we_req, sets done=1 and goes to DONE immediately, so the CPU is released without waiting for the ack.
  - A pending_wr flag is set while we_req != we_ack.
  - Any new read or write edge while pending_wr=1 keeps cpu_wait high. The FSM holds in IDLE until we_ack==we_req, then processes the edge, so a read never overtakes a posted write.
- Undefined: writes wait in WR for the ack as described above; pending_wr does not exist.

Test Plan:
- Write: cpu_bank=0x000, cpu_addr=0x1234, cpu_din=0xA5, cpu_wr pulse -> wraddr=0x0001234, din=0xA5, we_req toggles 0->1, cpu_wait stays high until we_ack=1, then low; we_req toggles exactly once.
- Read, cache miss: cpu_addr=0x1234, controller model returns 0x5A after 10 cycles -> rd_req rises once, rdaddr=0x0001234, cpu_dout=0x5A, cpu_wait low one cycle after rd_rdy rises.
- Read, cache hit: rd_rdy low for exactly 1 cycle -> FSM passes RD_ARM to RD_WAIT, cpu_dout is correct, no hang.
- Simultaneous cpu_rd and cpu_wr in the same cycle -> only the write is issued (we_req toggles, rd_req stays 0).
- reset_n pulled low in RD_WAIT -> rd_req=0, cpu_wait=0, dbg_state=IDLE immediately (async). After release, a read of 0x0000 completes normally.
- WR_POST_EN: write then read back-to-back with ack delayed 20 cycles -> the write releases cpu_wait in ≤2 cycles after the edge. rd_req does not rise until we_ack==we_req, and the read returns the written byte.

Source files
------------

// File: rtl/cpu_ddram_bridge.sv
// cpu_ddram_bridge
//
// Bridges an asynchronous 8-bit CPU memory cycle (level RD/WR strobes, WAIT
// output) onto the DDRAM cache controller handshakes: toggle-style write
// (we_req/we_ack) and edge-started read (rd_req/rd_rdy). The CPU address is
// widened to 28 bits with cpu_bank. Everything runs on DDRAM_CLK.
//
// Optional feature: define WR_POST_EN for a one-deep posted write. The CPU is
// released as soon as the write is issued; later edges wait in IDLE until the
// controller acknowledges, so a read never overtakes a posted write.
//
// Ports:
//   DDRAM_CLK, reset_n        clock, async active-low reset
//   cpu_addr, cpu_bank        CPU byte address and upper address bits
//   cpu_din, cpu_dout         CPU write data, registered read data
//   cpu_rd, cpu_wr            async strobes, active high
//   cpu_wait                  high stretches the CPU cycle (combinational)
//   wraddr, din, we_req       write request to controller
//   we_ack                    write acknowledge from controller
//   rdaddr, rd_req            read request to controller
//   dout, rd_rdy              read data / ready from controller
//   dbg_state                 current FSM state encoding

module cpu_ddram_bridge #(
    parameter int unsigned CPU_AW      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                DDRAM_CLK,
    input  logic                reset_n,
    input  logic [CPU_AW-1:0]   cpu_addr,
    input  logic [27-CPU_AW:0]  cpu_bank,
    input  logic [7:0]          cpu_din,
    input  logic                cpu_rd,
    input  logic                cpu_wr,
    output logic [7:0]          cpu_dout,
    output logic                cpu_wait,
    output logic [27:0]         wraddr,
    output logic [7:0]          din,
    output logic                we_req,
    input  logic                we_ack,
    output logic [27:0]         rdaddr,
    input  logic [7:0]          dout,
    output logic                rd_req,
    input  logic                rd_rdy,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWr     = 3'd1,
        StRdArm  = 3'd2,
        StRdWait = 3'd3,
        StDone   = 3'd4
    } state_e;

    state_e state;

    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic                   rd_s_dly;
    logic                   wr_s_dly;
    logic                   rd_s;
    logic                   wr_s;
    logic                   rd_rise;
    logic                   wr_rise;
    logic                   rd_evt;
    logic                   wr_evt;
    logic                   can_issue;
    logic                   done;
    logic [27:0]            cpu_full_addr;

    assign cpu_full_addr = {cpu_bank, cpu_addr};
    assign rd_s          = rd_sync[SYNC_STAGES-1];
    assign wr_s          = wr_sync[SYNC_STAGES-1];
    assign rd_rise       = rd_s & ~rd_s_dly;
    assign wr_rise       = wr_s & ~wr_s_dly;
    assign dbg_state     = state;

`ifdef WR_POST_EN
    logic pending_wr;
    logic rd_hold;
    logic wr_hold;

    assign pending_wr = (we_req != we_ack);
    // Edges arriving while a posted write is outstanding are parked here.
    assign rd_evt     = rd_rise | rd_hold;
    assign wr_evt     = wr_rise | wr_hold;
    assign can_issue  = ~pending_wr;
`else
    assign rd_evt     = rd_rise;
    assign wr_evt     = wr_rise;
    assign can_issue  = 1'b1;
`endif

    // WAIT must assert as soon as the raw strobe does, before synchronisation.
    always_comb begin
        cpu_wait = reset_n & (cpu_rd | cpu_wr) & ~done;
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            rd_sync  <= '0;
            wr_sync  <= '0;
            rd_s_dly <= 1'b0;
            wr_s_dly <= 1'b0;
        end else begin
            rd_sync  <= {rd_sync[SYNC_STAGES-2:0], cpu_rd};
            wr_sync  <= {wr_sync[SYNC_STAGES-2:0], cpu_wr};
            rd_s_dly <= rd_s;
            wr_s_dly <= wr_s;
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            we_req   <= 1'b0;
            rd_req   <= 1'b0;
            wraddr   <= '0;
            rdaddr   <= '0;
            din      <= '0;
            cpu_dout <= '0;
            done     <= 1'b0;
`ifdef WR_POST_EN
            rd_hold  <= 1'b0;
            wr_hold  <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
`ifdef WR_POST_EN
                    if (!can_issue) begin
                        rd_hold <= rd_evt;
                        wr_hold <= wr_evt;
                    end else begin
                        rd_hold <= 1'b0;
                        wr_hold <= 1'b0;
                    end
`endif
                    if (can_issue) begin
                        // A write edge wins; a coincident read edge is dropped.
                        if (wr_evt) begin
                            wraddr <= cpu_full_addr;
                            din    <= cpu_din;
                            we_req <= ~we_req;
`ifdef WR_POST_EN
                            done   <= 1'b1;
                            state  <= StDone;
`else
                            state  <= StWr;
`endif
                        end else if (rd_evt) begin
                            rdaddr <= cpu_full_addr;
                            rd_req <= 1'b1;
                            state  <= StRdArm;
                        end
                    end
                end
                StWr: begin
                    if (we_ack == we_req) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StRdArm: begin
                    // rd_rdy=1 here is left over from the previous read.
                    if (!rd_rdy) begin
                        state <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (rd_rdy) begin
                        cpu_dout <= dout;
                        rd_req   <= 1'b0;
                        done     <= 1'b1;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    if (!rd_s && !wr_s) begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ddram_bridge.sv
module tb_cpu_ddram_bridge;

    localparam int unsigned CPU_AW      = 16;
    localparam int unsigned SYNC_STAGES = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [CPU_AW-1:0]  cpu_addr;
    logic [27-CPU_AW:0] cpu_bank;
    logic [7:0]         cpu_din;
    logic               cpu_rd;
    logic               cpu_wr;
    logic [7:0]         cpu_dout;
    logic               cpu_wait;
    logic [27:0]        wraddr;
    logic [7:0]         din;
    logic               we_req;
    logic               we_ack;
    logic [27:0]        rdaddr;
    logic [7:0]         dout;
    logic               rd_req;
    logic               rd_rdy;
    logic [2:0]         dbg_state;

    always #5 clk = ~clk;

    cpu_ddram_bridge #(
        .CPU_AW      (CPU_AW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .DDRAM_CLK (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_bank  (cpu_bank),
        .cpu_din   (cpu_din),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_dout  (cpu_dout),
        .cpu_wait  (cpu_wait),
        .wraddr    (wraddr),
        .din       (din),
        .we_req    (we_req),
        .we_ack    (we_ack),
        .rdaddr    (rdaddr),
        .dout      (dout),
        .rd_req    (rd_req),
        .rd_rdy    (rd_rdy),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CPU-visible memory: the value last written to each 28-bit address.
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] ref_read(input logic [27:0] a);
        int k;
        k = int'({4'b0, a});
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    // Controller model: backing store plus handshake timing.
    logic [7:0] ddr_mem [int];
    int         cyc = 0;
    int         wr_delay = 0;
    int         rd_lat = 1;
    int         wr_cnt;
    int         rd_cnt;
    int         rd_phase;
    int         we_toggles = 0;
    int         rd_rises = 0;
    int         rd_over_pending = 0;
    int         rdy_rise_cyc = 0;
    logic       wr_busy;
    logic       we_req_prev;
    logic       rd_req_prev;
    logic [27:0] wr_addr_cap = '0;
    logic [7:0]  wr_data_cap = '0;
    logic [27:0] rd_addr_cap = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_ack      <= 1'b0;
            rd_rdy      <= 1'b1;
            dout        <= 8'h00;
            wr_busy     = 1'b0;
            rd_phase    = 0;
            we_req_prev = 1'b0;
            rd_req_prev = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (we_req !== we_req_prev) we_toggles++;
            we_req_prev = we_req;
            // Read side: drop one cycle after seeing the rise, low for rd_lat cycles.
            if (rd_phase == 1) begin
                rd_rdy   <= 1'b0;
                dout     <= 8'($urandom);
                rd_cnt   = rd_lat;
                rd_phase = 2;
            end else if (rd_phase == 2) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    rd_rdy       <= 1'b1;
                    dout         <= ddr_mem.exists(int'({4'b0, rd_addr_cap})) ?
                                    ddr_mem[int'({4'b0, rd_addr_cap})] : 8'h00;
                    rdy_rise_cyc = cyc;
                    rd_phase     = 0;
                end else begin
                    dout <= 8'($urandom);
                end
            end
            if (rd_req && !rd_req_prev) begin
                rd_rises++;
                rd_addr_cap = rdaddr;
                if (we_req != we_ack) rd_over_pending++;
                rd_phase = 1;
            end
            rd_req_prev = rd_req;
            // Write side: store and acknowledge wr_delay cycles after noticing.
            if (wr_busy) begin
                if (wr_cnt == 0) begin
                    ddr_mem[int'({4'b0, wr_addr_cap})] = wr_data_cap;
                    we_ack  <= we_req;
                    wr_busy = 1'b0;
                end else begin
                    wr_cnt--;
                end
            end else if (we_req != we_ack) begin
                wr_busy     = 1'b1;
                wr_cnt      = wr_delay;
                wr_addr_cap = wraddr;
                wr_data_cap = din;
            end
        end
    end

    task automatic cpu_idle_wait();
        int n = 0;
        while (dbg_state !== 3'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("idle_timeout", 32'(dbg_state), 32'd0);
        @(negedge clk);
    endtask

    task automatic ack_settle_wait();
        int n = 0;
        while (we_ack !== we_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("ack_timeout", 32'(we_ack), 32'(we_req));
    endtask

    task automatic cpu_write(input logic [27-CPU_AW:0] bank, input logic [CPU_AW-1:0] addr,
                             input logic [7:0] data);
        logic [27:0] full;
        int t0;
        int n = 0;
        full = {bank, addr};
        t0 = we_toggles;
        @(negedge clk);
        cpu_bank = bank;
        cpu_addr = addr;
        cpu_din  = data;
        cpu_wr   = 1'b1;
        #1 check_eq("wr_wait_on", 32'(cpu_wait), 32'd1);
        while (cpu_wait === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("wr_release", 32'(cpu_wait), 32'd0);
`ifdef WR_POST_EN
        check_eq("wr_post_fast", 32'(n <= int'(SYNC_STAGES) + 2), 32'd1);
`else
        check_eq("wr_ack_before_release", 32'(we_ack), 32'(we_req));
`endif
        check_eq("wr_toggle_once", 32'(we_toggles - t0), 32'd1);
        check_eq("wraddr", 32'(wraddr), 32'(full));
        ref_mem[int'({4'b0, full})] = data;
        cpu_wr = 1'b0;
        cpu_idle_wait();
        check_eq("ctl_wr_addr", 32'(wr_addr_cap), 32'(full));
        check_eq("ctl_wr_data", 32'(wr_data_cap), 32'(data));
    endtask

    task automatic cpu_read(input logic [27-CPU_AW:0] bank, input logic [CPU_AW-1:0] addr,
                            input int lat);
        logic [27:0] full;
        int r0;
        int n = 0;
        full   = {bank, addr};
        r0     = rd_rises;
        rd_lat = lat;
        @(negedge clk);
        cpu_bank = bank;
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        #1 check_eq("rd_wait_on", 32'(cpu_wait), 32'd1);
        while (cpu_wait === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_release", 32'(cpu_wait), 32'd0);
        check_eq("rd_data", 32'(cpu_dout), 32'(ref_read(full)));
        check_eq("rd_req_once", 32'(rd_rises - r0), 32'd1);
        check_eq("rdaddr_held", 32'(rdaddr), 32'(full));
        check_eq("ctl_rd_addr", 32'(rd_addr_cap), 32'(full));
        check_eq("rd_release_lat", 32'(cyc - rdy_rise_cyc), 32'd1);
        cpu_rd = 1'b0;
        cpu_idle_wait();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27-CPU_AW:0] banks [2];
        logic [CPU_AW-1:0]  addrs [4];
        int t0;
        int r0;
        int n;
        banks[0] = '0;
        banks[1] = 12'hABC;
        addrs[0] = 16'h0000;
        addrs[1] = 16'h1234;
        addrs[2] = 16'hFFFF;
        addrs[3] = 16'h00FF;

        reset_n  = 1'b0;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = '0;
        cpu_bank = '0;
        cpu_din  = '0;
        #23;
        check_eq("rst_wait", 32'(cpu_wait), 32'd0);
        check_eq("rst_we_req", 32'(we_req), 32'd0);
        check_eq("rst_rd_req", 32'(rd_req), 32'd0);
        check_eq("rst_wraddr", 32'(wraddr), 32'd0);
        check_eq("rst_rdaddr", 32'(rdaddr), 32'd0);
        check_eq("rst_din", 32'(din), 32'd0);
        check_eq("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        cpu_rd = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed: write, miss read, hit read.
        wr_delay = 4;
        cpu_write(12'h000, 16'h1234, 8'hA5);
        cpu_read(12'h000, 16'h1234, 10);
        cpu_write(12'h000, 16'h1234, 8'h5A);
        cpu_read(12'h000, 16'h1234, 1);

        // Simultaneous strobes: only the write is issued.
        ack_settle_wait();
        cpu_idle_wait();
        t0 = we_toggles;
        r0 = rd_rises;
        @(negedge clk);
        cpu_bank = 12'h000;
        cpu_addr = 16'h0042;
        cpu_din  = 8'h3C;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b1;
        n = 0;
        #1;
        while (cpu_wait === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("both_release", 32'(cpu_wait), 32'd0);
        check_eq("both_we_toggle", 32'(we_toggles - t0), 32'd1);
        ref_mem[int'({4'b0, 28'h0000042})] = 8'h3C;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_idle_wait();
        repeat (5) @(negedge clk);
        check_eq("both_no_read", 32'(rd_rises - r0), 32'd0);
        check_eq("both_rd_req_low", 32'(rd_req), 32'd0);

`ifdef WR_POST_EN
        // Posted write followed at once by a read of the same byte.
        ack_settle_wait();
        wr_delay = 20;
        cpu_write(12'h001, 16'h0777, 8'hC3);
        cpu_read(12'h001, 16'h0777, 2);
        wr_delay = 2;
`endif

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [27-CPU_AW:0] b;
            logic [CPU_AW-1:0]  a;
            b = banks[$urandom_range(0, 1)];
            a = addrs[$urandom_range(0, 3)];
            wr_delay = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) cpu_write(b, a, 8'($urandom));
            else                           cpu_read(b, a, $urandom_range(1, 12));
        end

        // Reset while waiting for read data.
        ack_settle_wait();
        cpu_idle_wait();
        @(negedge clk);
        rd_lat   = 30;
        cpu_bank = 12'h000;
        cpu_addr = 16'h0055;
        cpu_rd   = 1'b1;
        n = 0;
        while (rd_rdy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_rdy_low", 32'(rd_rdy), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_rd_req", 32'(rd_req), 32'd0);
        check_eq("rst_mid_wait", 32'(cpu_wait), 32'd0);
        check_eq("rst_mid_state", 32'(dbg_state), 32'd0);
        cpu_rd = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        cpu_read(12'h000, 16'h0000, 3);

        check_eq("rd_no_overtake", 32'(rd_over_pending), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
